// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared defaults and capture-FSM encodings for rx_byte_fifo.
package rx_fifo_pkg;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;
endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: DEPTH x 8 byte storage, synchronous write, combinational read.
module rx_fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: captures bytes from a level-flag receiver with a one-cycle ack
// and buffers them in a FIFO with registered pop data and sticky overflow.
module rx_byte_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              rx_clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_complete_flag,
    output logic              rx_complete_del_flag,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_data_q, rd_data_d, mem_rdata;
    logic              rd_valid_q, overflow_q, overflow_d, empty_q, full_q;
    logic              wr_req, pop, wr_acc, drop;

    always_comb begin
        state_d = IDLE;
        wr_req  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_req  = rx_complete_flag;
                state_d = rx_complete_flag ? ACK : IDLE;
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: state_d = rx_complete_flag ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts the write.
    assign pop        = rd_en && !empty_q;
    assign wr_acc     = wr_req && (!full_q || pop);
    assign drop       = wr_req && !wr_acc;
    assign wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d    = (wr_acc && !pop) ? count_q + 1'b1 :
                        (pop && !wr_acc) ? count_q - 1'b1 : count_q;
    assign overflow_d = drop || (overflow_q && !ovf_clr);
    assign rd_data_d  = pop ? mem_rdata : rd_data_q;

    rx_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (rx_clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == FULL_CNT);
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= pop;
        end
    end

    assign rx_complete_del_flag = (state_q == ACK);
    assign rd_data              = rd_data_q;
    assign rd_valid             = rd_valid_q;
    assign empty                = empty_q;
    assign full                 = full_q;
    assign count                = count_q;
    assign overflow             = overflow_q;
endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries (power of two, 2..64).
REQ-002 Parameter ADDR_W, default 3, log2(DEPTH).
REQ-003 rx_clk  input  1  sole clock, 16x baud (153.6 kHz at 9600 baud), all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_data  input  8  byte from Receiver, valid while rx_complete_flag=1.
REQ-006 rx_complete_flag  input  1  Receiver "byte ready" level, held until acknowledged.
REQ-007 rx_complete_del_flag  output  1  acknowledge to Receiver, one-cycle pulse, clears its flag.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  8  registered head byte from the last accepted pop.
REQ-010 rd_valid  output  1  one-cycle pulse, rd_data updated this cycle.
REQ-011 empty / full  output  1 each  occupancy flags, registered.
REQ-012 count  output  ADDR_W+1  entries stored, 0..DEPTH.
REQ-013 overflow  output  1  sticky, set when a byte is dropped.
REQ-014 ovf_clr  input  1  clears overflow.

Function
REQ-015 Capture FSM states: IDLE, ACK, WAIT_LOW.
REQ-016 IDLE: rx_complete_flag=1 -> write rx_data (if not dropped), go to ACK.
REQ-017 ACK: rx_complete_del_flag=1 for exactly this one cycle, go to WAIT_LOW.
REQ-018 WAIT_LOW: stay until rx_complete_flag=0, then IDLE; no capture in ACK/WAIT_LOW, so a held flag yields exactly one write.
REQ-019 Capture-to-ack latency: flag sampled high at edge N -> rx_complete_del_flag high in cycle N+1.
REQ-020 Pop: rd_en=1 and empty=0 at edge N -> rd_data = head byte and rd_valid=1 after edge N, read pointer +1.
REQ-021 rd_en while empty: ignored, rd_data holds, rd_valid=0, no error flag.
REQ-022 Write while full with no pop the same cycle: byte dropped, overflow set, handshake still completes (ACK issued).
REQ-023 Write and pop the same cycle when full: both accepted, count unchanged, no overflow.
REQ-024 Write and pop the same cycle when empty: pop ignored, write accepted, count=1.
REQ-025 Pointers ADDR_W bits, wrap DEPTH-1 -> 0 modulo DEPTH; count tracks +1/-1/0 per cycle.
REQ-026 full = (count==DEPTH), empty = (count==0), both consistent with count in the same cycle.
REQ-027 ovf_clr and a same-cycle drop: set wins (overflow stays 1).
REQ-028 Order preserved: bytes popped in arrival order.

Reset
REQ-029 reset_n=0 forces immediately: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, rd_data=8'h00, rd_valid=0, rx_complete_del_flag=0.
REQ-030 Storage array not reset; contents undefined after reset.
REQ-031 Reset during ACK/WAIT_LOW: after release, a still-high rx_complete_flag is captured as a new byte.

Structure
REQ-032 Package rx_fifo_pkg holds DEPTH/ADDR_W defaults and FSM state encodings (IDLE=2'd0, ACK=2'd1, WAIT_LOW=2'd2).
REQ-033 One sub-module rx_fifo_mem: DEPTH x 8 register array, synchronous write, combinational read at read pointer.
REQ-034 Unused FSM encoding 2'd3 returns to IDLE next cycle.

Verification
REQ-035 Single byte: flag=1 with rx_data=8'h55 held 5 cycles -> one ack pulse at N+1, count=1; rd_en -> rd_data=8'h55, rd_valid pulse, empty=1.
REQ-036 Fill: 8 bytes 8'h01..8'h08 -> full=1, count=8; 9th byte 8'hAA -> acked, dropped, overflow=1; 8 pops return 8'h01..8'h08 in order.
REQ-037 Full plus same-cycle pop and capture of 8'hBB -> count stays 8, overflow=0, 8'hBB popped last.
REQ-038 Wrap: 20 push/pop pairs 8'h10..8'h23 -> every byte read back in order, pointers wrap twice, no overflow.
REQ-039 Reset asserted in WAIT_LOW with flag high -> outputs at reset values immediately; after release byte captured once, single ack.
REQ-040 rd_en on empty plus ovf_clr with concurrent drop -> no rd_valid, rd_data unchanged, overflow remains 1.
